// File: rtl/tmr_fault_monitor_if.sv
// Sample bus from the TMR voter stage into the fault monitor.
// Handshake: valid-only, no backpressure. When valid is high, a/b/c/voted
// form one sample that the monitor consumes on that rising edge. The
// monitor is always ready, so the bus carries no ready signal.
interface tmr_fault_monitor_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] voted;

  modport master (output valid, a, b, c, voted);
  modport slave  (input  valid, a, b, c, voted);
endinterface

// File: rtl/tmr_fault_monitor.sv
// Classifies each TMR replica against the voted word on every valid sample.
// It tracks per-replica health (HEALTHY/SUSPECT/FAILED) and keeps saturating
// error counts. It also flags samples where two or more replicas disagree
// with the vote, because such a vote cannot be trusted.
module tmr_fault_monitor #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 8,
  parameter int FAIL_THRESH  = 3,
  parameter int CLEAN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tmr_fault_monitor_if.slave   smp,
  input  logic                 clr,
  output logic [1:0]           state_a,
  output logic [1:0]           state_b,
  output logic [1:0]           state_c,
  output logic [CNT_W-1:0]     err_cnt_a,
  output logic [CNT_W-1:0]     err_cnt_b,
  output logic [CNT_W-1:0]     err_cnt_c,
  output logic                 multi_err,
  output logic                 irq
);

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10
  } health_t;

  localparam logic [3:0]       FT      = 4'(FAIL_THRESH);
  localparam logic [3:0]       CC      = 4'(CLEAN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] lane_w [3];
  logic [2:0]       mis;
  logic             two_plus;

  health_t          st_q   [3];
  health_t          st_d   [3];
  logic [3:0]       mrun_q [3];
  logic [3:0]       mrun_d [3];
  logic [3:0]       crun_q [3];
  logic [3:0]       crun_d [3];
  logic [CNT_W-1:0] cnt_q  [3];
  logic [CNT_W-1:0] cnt_d  [3];
  logic             multi_q, multi_d;
  logic             irq_q, irq_d;
  logic             enter_fail;

  assign lane_w[0] = smp.a;
  assign lane_w[1] = smp.b;
  assign lane_w[2] = smp.c;

  // Per-lane full-width disagreement with the vote, and the two-or-more case.
  always_comb begin
    for (int i = 0; i < 3; i++) mis[i] = (lane_w[i] != smp.voted);
    two_plus = (mis[0] & mis[1]) | (mis[0] & mis[2]) | (mis[1] & mis[2]);
  end

  // Next-state logic. clr beats valid, and an idle cycle freezes everything except irq.
  always_comb begin
    st_d       = st_q;
    mrun_d     = mrun_q;
    crun_d     = crun_q;
    cnt_d      = cnt_q;
    multi_d    = multi_q;
    irq_d      = 1'b0;
    enter_fail = 1'b0;
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        st_d[i]   = HEALTHY;
        mrun_d[i] = 4'd0;
        crun_d[i] = 4'd0;
        cnt_d[i]  = '0;
      end
      multi_d = 1'b0;
    end else if (smp.valid) begin
      for (int i = 0; i < 3; i++) begin
        if (mis[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_ONE;
        case (st_q[i])
          HEALTHY: begin
            if (mis[i]) begin
              mrun_d[i] = 4'd1;
              crun_d[i] = 4'd0;
              if (FT == 4'd1) begin
                st_d[i]    = FAILED;
                enter_fail = 1'b1;
              end else begin
                st_d[i] = SUSPECT;
              end
            end
          end
          SUSPECT: begin
            if (mis[i]) begin
              mrun_d[i] = mrun_q[i] + 4'd1;
              crun_d[i] = 4'd0;
              if ((mrun_q[i] + 4'd1) == FT) begin
                st_d[i]    = FAILED;
                enter_fail = 1'b1;
              end
            end else begin
              mrun_d[i] = 4'd0;
              crun_d[i] = crun_q[i] + 4'd1;
              if ((crun_q[i] + 4'd1) == CC) begin
                st_d[i]   = HEALTHY;
                crun_d[i] = 4'd0;
              end
            end
          end
          FAILED:  st_d[i] = FAILED;
          default: st_d[i] = HEALTHY;
        endcase
      end
      if (two_plus) multi_d = 1'b1;
      irq_d = enter_fail | (two_plus & ~multi_q);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]   <= HEALTHY;
        mrun_q[i] <= 4'd0;
        crun_q[i] <= 4'd0;
        cnt_q[i]  <= '0;
      end
      multi_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      mrun_q  <= mrun_d;
      crun_q  <= crun_d;
      cnt_q   <= cnt_d;
      multi_q <= multi_d;
      irq_q   <= irq_d;
    end
  end

  assign state_a   = st_q[0];
  assign state_b   = st_q[1];
  assign state_c   = st_q[2];
  assign err_cnt_a = cnt_q[0];
  assign err_cnt_b = cnt_q[1];
  assign err_cnt_c = cnt_q[2];
  assign multi_err = multi_q;
  assign irq       = irq_q;

endmodule
